// File: rtl/key_pkg.sv
// Shared definitions for the keyboard-to-character controller: caps state
// encoding, special PS/2 set-2 scan codes and the letter scan-code table.
package key_pkg;

   typedef enum logic {
      LOWER = 1'b0,
      UPPER = 1'b1
   } caps_e;

   localparam logic [7:0] SC_CAPS   = 8'h58;
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;
   localparam logic [7:0] SC_SPACE  = 8'h29;
   localparam logic [7:0] SC_ENTER  = 8'h5A;

   localparam int unsigned N_LETTERS = 26;

   // Set-2 make codes for A..Z, indexed by letter position
   localparam logic [7:0] LETTER_CODES [N_LETTERS] = '{
      8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
      8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
      8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A
   };

   // Returns {hit, index[4:0]} for a scan code against the letter table
   function automatic logic [5:0] letter_lookup(input logic [7:0] code);
      logic       hit;
      logic [4:0] idx;
      hit = 1'b0;
      idx = 5'd0;
      for (int i = 0; i < int'(N_LETTERS); i++) begin
         if (code == LETTER_CODES[i]) begin
            hit = 1'b1;
            idx = 5'(i);
         end
      end
      return {hit, idx};
   endfunction

endpackage

// File: rtl/char_fifo.sv
// Character FIFO with drop-on-full write and simultaneous pop/push when full.
module char_fifo #(
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       wr_en,
   input  logic [7:0] wr_data,
   input  logic       rd_en,
   output logic       rd_valid,
   output logic [7:0] rd_data,
   output logic       overflow
);

   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = AW + 1;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          overflow_q, overflow_d;
   logic          full, empty, pop, push;

   assign empty = (count_q == CW'(0));
   assign full  = (count_q == CW'(FIFO_DEPTH));
   assign pop   = rd_en && !empty;
   assign push  = wr_en && (!full || pop);

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = wr_en && full && !pop;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage needs no reset: the head is masked while empty
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= wr_data;
   end

   assign rd_valid = !empty;
   assign rd_data  = empty ? 8'h00 : mem[rd_ptr_q];
   assign overflow = overflow_q;

endmodule

// File: rtl/key_char_ctrl.sv
// Turns decoded PS/2 key events into ASCII characters, tracking caps lock
// and shift state, and buffers them in a small FIFO for the consumer.
module key_char_ctrl
   import key_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_valid,
   input  logic       key_make,
   input  logic [7:0] key_code,
   input  logic       out_ready,
   output logic       out_valid,
   output logic [7:0] out_char,
   output logic       caps_led,
   output logic       overflow
);

   caps_e      caps_q, caps_d;
   logic       held_q, held_d;
   logic       lshift_q, lshift_d;
   logic       rshift_q, rshift_d;
   logic       dec_vld_q, dec_vld_d;
   logic [7:0] dec_char_q, dec_char_d;
   logic [5:0] lut;
   logic       upper;

   assign lut   = letter_lookup(key_code);
   assign upper = (caps_q == UPPER) ^ (lshift_q | rshift_q);

   // Next-state for caps FSM, modifier flags and the decode stage
   always_comb begin
      caps_d     = caps_q;
      held_d     = held_q;
      lshift_d   = lshift_q;
      rshift_d   = rshift_q;
      dec_vld_d  = 1'b0;
      dec_char_d = 8'h00;
      if (key_valid) begin
         case (key_code)
            SC_CAPS: begin
               if (key_make) begin
                  if (!held_q) caps_d = (caps_q == LOWER) ? UPPER : LOWER;
                  held_d = 1'b1;
               end else begin
                  held_d = 1'b0;
               end
            end
            SC_LSHIFT: lshift_d = key_make;
            SC_RSHIFT: rshift_d = key_make;
            SC_SPACE: begin
               dec_vld_d  = key_make;
               dec_char_d = 8'h20;
            end
            SC_ENTER: begin
               dec_vld_d  = key_make;
               dec_char_d = 8'h0D;
            end
            default: begin
               if (key_make && lut[5]) begin
                  dec_vld_d  = 1'b1;
                  dec_char_d = (upper ? 8'h41 : 8'h61) + {3'b000, lut[4:0]};
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         caps_q     <= LOWER;
         held_q     <= 1'b0;
         lshift_q   <= 1'b0;
         rshift_q   <= 1'b0;
         dec_vld_q  <= 1'b0;
         dec_char_q <= 8'h00;
      end else begin
         caps_q     <= caps_d;
         held_q     <= held_d;
         lshift_q   <= lshift_d;
         rshift_q   <= rshift_d;
         dec_vld_q  <= dec_vld_d;
         dec_char_q <= dec_char_d;
      end
   end

   assign caps_led = (caps_q == UPPER);

   char_fifo #(
      .FIFO_DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (dec_vld_q),
      .wr_data  (dec_char_q),
      .rd_en    (out_ready),
      .rd_valid (out_valid),
      .rd_data  (out_char),
      .overflow (overflow)
   );

endmodule

// File: tb/tb_key_char_ctrl.sv
// Directed bench for key_char_ctrl: case handling, caps debounce, FIFO
// ordering/overflow and reset discard.
module tb_key_char_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       key_valid;
   logic       key_make;
   logic [7:0] key_code;
   logic       out_ready;
   logic       out_valid;
   logic [7:0] out_char;
   logic       caps_led;
   logic       overflow;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   key_char_ctrl #(
      .FIFO_DEPTH(4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_valid (key_valid),
      .key_make  (key_make),
      .key_code  (key_code),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_char  (out_char),
      .caps_led  (caps_led),
      .overflow  (overflow)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic mk, input logic [7:0] code);
      key_valid = 1'b1;
      key_make  = mk;
      key_code  = code;
      tick();
      key_valid = 1'b0;
      key_make  = 1'b0;
      key_code  = 8'h00;
   endtask

   task automatic pop();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n     = 1'b0;
      key_valid = 1'b0;
      key_make  = 1'b0;
      key_code  = 8'h00;
      out_ready = 1'b0;
      tick();
      tick();
      chk("rst_valid", 8'(out_valid), 8'h00);
      chk("rst_char",  out_char,       8'h00);
      chk("rst_caps",  8'(caps_led),  8'h00);
      chk("rst_ovf",   8'(overflow),  8'h00);
      rst_n = 1'b1;
      tick();

      // Single letter: latency of two edges, then pop empties
      send(1'b1, 8'h1C);
      chk("a_lat_valid", 8'(out_valid), 8'h00);
      tick();
      chk("a_valid", 8'(out_valid), 8'h01);
      chk("a_char",  out_char,       8'h61);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("a_popped", 8'(out_valid), 8'h00);
      chk("a_empty_char", out_char, 8'h00);
      pop();
      chk("empty_pop", 8'(out_valid), 8'h00);

      // Caps lock with typematic repeats
      send(1'b1, 8'h58);
      chk("caps_t1", 8'(caps_led), 8'h01);
      send(1'b1, 8'h58);
      send(1'b1, 8'h58);
      chk("caps_rep", 8'(caps_led), 8'h01);
      send(1'b0, 8'h58);
      chk("caps_brk", 8'(caps_led), 8'h01);
      send(1'b1, 8'h58);
      chk("caps_t2", 8'(caps_led), 8'h00);
      send(1'b1, 8'h1C);
      tick();
      chk("caps_lower_a", out_char, 8'h61);
      pop();
      chk("caps_lower_pop", 8'(out_valid), 8'h00);

      // Shift inverts upper-case mode; back-to-back events
      send(1'b0, 8'h58);
      send(1'b1, 8'h58);
      chk("upper_on", 8'(caps_led), 8'h01);
      send(1'b1, 8'h12);
      send(1'b1, 8'h1C);
      send(1'b0, 8'h12);
      send(1'b1, 8'h1C);
      tick();
      chk("shift_up_a", out_char, 8'h61);
      pop();
      chk("up_a", out_char, 8'h41);
      pop();
      chk("shift_empty", 8'(out_valid), 8'h00);
      send(1'b0, 8'h58);
      send(1'b1, 8'h58);
      send(1'b0, 8'h58);
      chk("lower_again", 8'(caps_led), 8'h00);
      send(1'b1, 8'h59);
      send(1'b1, 8'h32);
      send(1'b0, 8'h59);
      send(1'b1, 8'h32);
      tick();
      chk("rshift_B", out_char, 8'h42);
      pop();
      chk("plain_b", out_char, 8'h62);
      pop();

      // Overflow: five letters into a depth-4 FIFO
      send(1'b1, 8'h1C);
      send(1'b1, 8'h32);
      send(1'b1, 8'h21);
      send(1'b1, 8'h23);
      send(1'b1, 8'h24);
      chk("ovf_pre", 8'(overflow), 8'h00);
      tick();
      chk("ovf_pulse", 8'(overflow), 8'h01);
      tick();
      chk("ovf_clear", 8'(overflow), 8'h00);
      chk("ovf_h0", out_char, 8'h61);
      pop();
      chk("ovf_h1", out_char, 8'h62);
      pop();
      chk("ovf_h2", out_char, 8'h63);
      pop();
      chk("ovf_h3", out_char, 8'h64);
      pop();
      chk("ovf_drained", 8'(out_valid), 8'h00);

      // Full FIFO with simultaneous pop and write: no drop
      send(1'b1, 8'h2B);
      send(1'b1, 8'h34);
      send(1'b1, 8'h33);
      send(1'b1, 8'h43);
      send(1'b1, 8'h3B);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("fullrw_ovf", 8'(overflow), 8'h00);
      chk("fullrw_g", out_char, 8'h67);
      pop();
      chk("fullrw_h", out_char, 8'h68);
      pop();
      chk("fullrw_i", out_char, 8'h69);
      pop();
      chk("fullrw_j", out_char, 8'h6A);
      pop();
      chk("fullrw_empty", 8'(out_valid), 8'h00);

      // Space/enter only on make; other codes ignored
      send(1'b1, 8'h29);
      send(1'b0, 8'h29);
      send(1'b1, 8'h5A);
      send(1'b1, 8'h76);
      tick();
      tick();
      chk("sp_char", out_char, 8'h20);
      pop();
      chk("cr_char", out_char, 8'h0D);
      pop();
      chk("sp_cr_only", 8'(out_valid), 8'h00);

      // Reset mid-operation discards queued and in-flight characters
      send(1'b1, 8'h58);
      chk("rst_pre_upper", 8'(caps_led), 8'h01);
      send(1'b1, 8'h1C);
      send(1'b1, 8'h32);
      tick();
      chk("rst_pre_A", out_char, 8'h41);
      send(1'b1, 8'h21);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("mid_rst_valid", 8'(out_valid), 8'h00);
      chk("mid_rst_caps",  8'(caps_led),  8'h00);
      chk("mid_rst_char",  out_char,       8'h00);
      tick();
      tick();
      chk("inflight_gone", 8'(out_valid), 8'h00);
      send(1'b1, 8'h58);
      chk("held_cleared", 8'(caps_led), 8'h01);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/key_char_ctrl.md
KEY_CHAR_CTRL -- requirements
Module: key_char_ctrl

Interface
REQ-001 The block SHALL have one parameter: FIFO_DEPTH, default 4, number of buffered characters (power of two, 2..16).
REQ-002 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 Port key_valid, input, 1 bit: one-cycle strobe marking a decoded key event.
REQ-005 Port key_make, input, 1 bit: 1 = press (make), 0 = release (break); sampled with key_valid.
REQ-006 Port key_code, input, 8 bits: PS/2 set-2 scan code; sampled with key_valid.
REQ-007 Port out_ready, input, 1 bit: consumer accepts the head character.
REQ-008 Port out_valid, output, 1 bit: FIFO non-empty.
REQ-009 Port out_char, output, 8 bits: ASCII code at the FIFO head; 0x00 when empty.
REQ-010 Port caps_led, output, 1 bit: 1 while in upper-case mode.
REQ-011 Port overflow, output, 1 bit: one-cycle pulse when a character is dropped.

Function
REQ-012 The caps FSM SHALL have two states, LOWER and UPPER, and reset to LOWER.
REQ-013 A make event with key_code 0x58 SHALL toggle the caps state only if caps_held is 0; caps_held SHALL then be set.
REQ-014 A break event with key_code 0x58 SHALL clear caps_held and leave the caps state unchanged; typematic repeats of 0x58 therefore cause no toggle.
REQ-015 caps_led SHALL be registered, equal 1 in UPPER, and update on the cycle after the toggling event.
REQ-016 lshift and rshift SHALL set on make and clear on break of 0x12 and 0x59 respectively; shift = lshift OR rshift.
REQ-017 A make event of a letter scan code (A..Z, set-2 table) SHALL yield 'A'+idx when (UPPER XOR shift), otherwise 'a'+idx.
REQ-018 A make event of 0x29 SHALL yield 0x20, and a make event of 0x5A SHALL yield 0x0D, regardless of case.
REQ-019 Break events, and make events of any other code, SHALL yield no character.
REQ-020 Case SHALL be evaluated with caps and shift as registered before the current event.
REQ-021 A character SHALL be registered in a decode stage at edge N+1 and written to the FIFO at edge N+2; out_valid SHALL rise after edge N+2 when the FIFO was empty.
REQ-022 A pop SHALL occur when out_valid AND out_ready; out_char SHALL show the next entry on the following cycle.
REQ-023 When the FIFO is full and no pop occurs, a write SHALL drop the character, leave the FIFO contents unchanged and pulse overflow at edge N+2.
REQ-024 When the FIFO is full and a pop and a write coincide, both SHALL succeed and overflow SHALL stay 0.
REQ-025 When the FIFO is empty, out_ready SHALL have no effect.
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL be log2(FIFO_DEPTH)+1 bits wide.
REQ-027 Back-to-back key_valid on consecutive cycles SHALL be fully supported, with no event lost.

Reset
REQ-028 With rst_n=0 at a rising edge, the block SHALL set: caps state LOWER, caps_held/lshift/rshift 0, decode stage empty, FIFO empty, out_valid 0, out_char 0x00, caps_led 0, overflow 0.
REQ-029 Reset SHALL take priority over every concurrent event, and a reset mid-operation SHALL discard buffered and in-flight characters.

Structure
REQ-030 A shared package key_pkg SHALL hold the caps-state encoding (LOWER=0, UPPER=1), special scan codes (0x58, 0x12, 0x59, 0x29, 0x5A) and the 26-entry letter scan-code table.
REQ-031 The FIFO SHALL be a sub-module, char_fifo (parameter FIFO_DEPTH, 8-bit data), with the same clk/rst_n.

Verification
REQ-032 Reset, then key make 0x1C (a) -> out_char 0x61 and out_valid=1 two edges later; pulse out_ready -> out_valid=0.
REQ-033 Make 0x58 three times, then break 0x58, then make 0x58 -> caps_led 0->1 once, then 1->0 after the second toggle; make 0x1C after that -> 0x61.
REQ-034 Make 0x12, make 0x1C, break 0x12, make 0x1C in UPPER mode -> characters 0x61, 0x41.
REQ-035 FIFO_DEPTH=4, out_ready=0, five letter makes -> 4 entries retained in order, overflow pulses once; the fifth make with out_ready=1 on its write edge -> no overflow.
REQ-036 Make 0x29, break 0x29, make 0x5A, make 0x76 (other code) -> exactly 0x20, 0x0D queued.
REQ-037 Two characters queued and UPPER mode, then assert rst_n=0 for one edge -> out_valid=0, caps_led=0, and an in-flight character is discarded.
